// File: rtl/vending_pkg.sv
// Shared definitions for the multi-item vending machine: state encoding,
// default price/coin tables and a width helper.
package vending_pkg;

  // Controller states: IDLE accepts button presses, the others are timed indications
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_ERR    = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  // Number of coin inputs and of debounced button channels (L, R, U, D, SW[3:0])
  localparam int N_COINS = 4;
  localparam int N_BTN   = 8;

  // Default item prices, item 0 in the least significant byte
  localparam logic [31:0] DEFAULT_PRICES    = {8'd10, 8'd7, 8'd5, 8'd3};
  // Default coin values, SW[0] in the least significant byte
  localparam logic [31:0] DEFAULT_COIN_VALS = {8'd10, 8'd5, 8'd2, 8'd1};

  // Ceiling log2, never less than 1 so it can size a vector directly
  function automatic int vw_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Falling-edge detector for one active-low button: the input is registered
// once and compared to its previous sample, giving a single-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sample_reg;
  logic hist_reg;

  // Sample the raw button and keep one cycle of history; released level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_reg <= 1'b1;
      hist_reg   <= 1'b1;
    end else begin
      sample_reg <= btn;
      hist_reg   <= sample_reg;
    end
  end

  assign pulse = hist_reg & ~sample_reg;

endmodule

// File: rtl/vending_multi.sv
// Multi-item vending controller: coin accumulation with saturation, item
// selection with wrap, per-item stock, and timed vend/error/refund indications.
module vending_multi
  import vending_pkg::*;
#(
  parameter int                          N_ITEMS    = 4,
  parameter int                          CREDIT_W   = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = (N_ITEMS*CREDIT_W)'(DEFAULT_PRICES),
  parameter logic [4*CREDIT_W-1:0]       COIN_VALS  = (4*CREDIT_W)'(DEFAULT_COIN_VALS),
  parameter logic [3:0]                  STOCK_INIT = 4'd3,
  parameter int                          HOLD_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                L,
  input  logic                R,
  input  logic                U,
  input  logic                D,
  input  logic [3:0]          SW,
  output logic [CREDIT_W-1:0] LED,
  output logic                RD,
  output logic                GN,
  output logic                YL
);

  localparam int SEL_W = vw_clog2(N_ITEMS);
  localparam int TMR_W = vw_clog2(HOLD_CYC);
  localparam logic [CREDIT_W+2:0] CREDIT_MAX = {3'b000, {CREDIT_W{1'b1}}};

  // Button channel order: SW[3:0] in bits 3:0, then D, U, R, L
  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] pulse;

  assign raw = {L, R, U, D, SW};

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (raw[gi]),
        .pulse (pulse[gi])
      );
    end
  endgenerate

  logic [N_COINS-1:0] p_sw;
  logic               p_d;
  logic               p_u;
  logic               p_r;
  logic               p_l;

  assign p_sw = pulse[3:0];
  assign p_d  = pulse[4];
  assign p_u  = pulse[5];
  assign p_r  = pulse[6];
  assign p_l  = pulse[7];

  state_t                state_reg,  state_next;
  logic [SEL_W-1:0]      sel_reg,    sel_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [CREDIT_W-1:0]   refund_reg, refund_next;
  logic [TMR_W-1:0]      timer_reg,  timer_next;

  logic [N_ITEMS-1:0]    dec_vec;
  logic [N_ITEMS-1:0]    restock_vec;
  logic [N_ITEMS*4-1:0]  stock_flat;

  // Per-item stock counters: restock wins over a decrement in the same cycle
  generate
    for (gi = 0; gi < N_ITEMS; gi++) begin : g_stock
      logic [3:0] cnt_reg;

      // Stock count for this item
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= STOCK_INIT;
        end else if (restock_vec[gi]) begin
          cnt_reg <= STOCK_INIT;
        end else if (dec_vec[gi]) begin
          cnt_reg <= cnt_reg - 4'd1;
        end
      end

      assign stock_flat[gi*4 +: 4] = cnt_reg;
    end
  endgenerate

  logic [3:0]          cur_stock;
  logic [CREDIT_W-1:0] cur_price;
  logic [CREDIT_W+1:0] coin_sum;
  logic [CREDIT_W+2:0] credit_sum;

  assign cur_stock = stock_flat[sel_reg*4 +: 4];
  assign cur_price = PRICES[sel_reg*CREDIT_W +: CREDIT_W];

  // Total value of all coins pressed this cycle, plus the widened new credit
  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (p_sw[i]) coin_sum = coin_sum + {2'b00, COIN_VALS[i*CREDIT_W +: CREDIT_W]};
    end
    credit_sum = {3'b000, credit_reg} + {1'b0, coin_sum};
  end

  // Controller state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      credit_reg <= '0;
      refund_reg <= '0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      credit_reg <= credit_next;
      refund_reg <= refund_next;
      timer_reg  <= timer_next;
    end
  end

  // Next-state logic: presses only matter in IDLE, priority D > U > coin > L/R
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    credit_next = credit_reg;
    refund_next = refund_reg;
    timer_next  = timer_reg;
    dec_vec     = '0;
    restock_vec = '0;

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (p_d) begin
          refund_next = credit_reg;
          credit_next = '0;
          state_next  = ST_REFUND;
        end else if (p_u) begin
          if ((cur_stock != 4'd0) && (credit_reg >= cur_price)) begin
            credit_next      = credit_reg - cur_price;
            dec_vec[sel_reg] = 1'b1;
            state_next       = ST_VEND;
          end else begin
            state_next = ST_ERR;
          end
        end else if (|p_sw) begin
          credit_next = (credit_sum > CREDIT_MAX) ? {CREDIT_W{1'b1}}
                                                  : credit_sum[CREDIT_W-1:0];
        end else if (p_l && p_r) begin
          restock_vec[sel_reg] = 1'b1;
        end else if (p_r) begin
          sel_next = (sel_reg == SEL_W'(N_ITEMS - 1)) ? '0 : sel_reg + 1'b1;
        end else if (p_l) begin
          sel_next = (sel_reg == '0) ? SEL_W'(N_ITEMS - 1) : sel_reg - 1'b1;
        end
      end

      default: begin
        // Timed indication: hold for HOLD_CYC cycles then go back to IDLE
        if (timer_reg == TMR_W'(HOLD_CYC - 1)) begin
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
    endcase
  end

  assign GN  = (state_reg == ST_VEND);
  assign RD  = (state_reg == ST_ERR);
  assign YL  = (state_reg == ST_REFUND);
  assign LED = (state_reg == ST_REFUND) ? refund_reg : credit_reg;

endmodule

// File: tb/tb_vending_multi.sv
// Scoreboard bench for vending_multi: a behavioural model predicts each
// operation's display, indicator, hold length and post-indication display.
module tb_vending_multi;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       L, R, U, D;
  logic [3:0] SW;
  logic [7:0] LED;
  logic       RD, GN, YL;

  vending_multi dut (
    .clk (clk),
    .rst (rst),
    .L   (L),
    .R   (R),
    .U   (U),
    .D   (D),
    .SW  (SW),
    .LED (LED),
    .RD  (RD),
    .GN  (GN),
    .YL  (YL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Indicator code {RD,GN,YL}
  localparam int IND_NONE = 0;
  localparam int IND_YL   = 1;
  localparam int IND_GN   = 2;
  localparam int IND_RD   = 4;

  // Press mask bits: 3:0 SW, 4 D, 5 U, 6 R, 7 L
  localparam logic [7:0] M_SW0 = 8'h01;
  localparam logic [7:0] M_SW1 = 8'h02;
  localparam logic [7:0] M_SW2 = 8'h04;
  localparam logic [7:0] M_SW3 = 8'h08;
  localparam logic [7:0] M_D   = 8'h10;
  localparam logic [7:0] M_U   = 8'h20;
  localparam logic [7:0] M_R   = 8'h40;
  localparam logic [7:0] M_L   = 8'h80;

  typedef struct {
    string tag;
    int    led;
    int    ind;
    int    hold;
    int    led_after;
  } exp_t;

  exp_t sb[$];

  int m_credit;
  int m_sel;
  int m_stock [4];
  int m_price [4] = '{3, 5, 7, 10};
  int m_coin  [4] = '{1, 2, 5, 10};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_sel    = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endtask

  // Predict the outcome of one press and queue it
  task automatic model_op(input string tag, input logic [7:0] m);
    exp_t e;
    int   sum;
    e.tag  = tag;
    e.ind  = IND_NONE;
    e.hold = 0;
    if (m[4]) begin
      e.led       = m_credit;
      m_credit    = 0;
      e.ind       = IND_YL;
      e.hold      = HOLD;
      e.led_after = 0;
    end else if (m[5]) begin
      if (m_stock[m_sel] > 0 && m_credit >= m_price[m_sel]) begin
        m_credit       = m_credit - m_price[m_sel];
        m_stock[m_sel] = m_stock[m_sel] - 1;
        e.ind          = IND_GN;
      end else begin
        e.ind = IND_RD;
      end
      e.led       = m_credit;
      e.hold      = HOLD;
      e.led_after = m_credit;
    end else begin
      if (m[3:0] != 4'b0) begin
        sum = 0;
        for (int i = 0; i < 4; i++) if (m[i]) sum += m_coin[i];
        m_credit = (m_credit + sum > 255) ? 255 : m_credit + sum;
      end else if (m[6] && m[7]) begin
        m_stock[m_sel] = 3;
      end else if (m[6]) begin
        m_sel = (m_sel + 1) % 4;
      end else if (m[7]) begin
        m_sel = (m_sel + 3) % 4;
      end
      e.led       = m_credit;
      e.led_after = m_credit;
    end
    sb.push_back(e);
  endtask

  // Hold the pressed buttons low for one cycle, then release all
  task automatic drive(input logic [7:0] m);
    @(negedge clk);
    SW = ~m[3:0];
    D  = ~m[4];
    U  = ~m[5];
    R  = ~m[6];
    L  = ~m[7];
    @(negedge clk);
    SW = 4'hF;
    D  = 1'b1;
    U  = 1'b1;
    R  = 1'b1;
    L  = 1'b1;
  endtask

  // One transaction: predict, drive, then pop and compare against the DUT
  task automatic op(input string tag, input logic [7:0] m, input bit disturb);
    exp_t e;
    int   cnt;
    int   guard;
    model_op(tag, m);
    drive(m);
    @(negedge clk);
    e = sb.pop_front();
    check_val({e.tag, "_led"}, LED, e.led);
    check_val({e.tag, "_ind"}, {RD, GN, YL}, e.ind);
    if (e.hold > 0) begin
      cnt   = 0;
      guard = 0;
      while (({29'd0, RD, GN, YL} == e.ind) && guard < 20) begin
        cnt++;
        guard++;
        @(negedge clk);
        if (disturb && guard == 1) begin
          U     = 1'b0;
          SW[3] = 1'b0;
        end
        if (disturb && guard == 2) begin
          U     = 1'b1;
          SW[3] = 1'b1;
        end
      end
      check_val({e.tag, "_hold"}, cnt, e.hold);
      check_val({e.tag, "_led_after"}, LED, e.led_after);
      check_val({e.tag, "_ind_after"}, {RD, GN, YL}, IND_NONE);
    end
    $display("txn %s led=%0d rd=%0d gn=%0d yl=%0d", e.tag, LED, RD, GN, YL);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    L   = 1'b1;
    R   = 1'b1;
    U   = 1'b1;
    D   = 1'b1;
    SW  = 4'hF;
    model_reset();
    #1;
    check_val("reset_led", LED, 0);
    check_val("reset_ind", {RD, GN, YL}, IND_NONE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First coin and selection wrap
    op("coin10", M_SW3, 1'b0);
    for (int i = 0; i < 4; i++) op("right", M_R, 1'b0);
    op("left", M_L, 1'b0);

    // Exact-credit purchase of item 3, then a purchase with no credit
    op("buy_item3", M_U, 1'b0);
    op("buy_item3_broke", M_U, 1'b0);

    // Item 0: three purchases empty the stock, fourth is sold out, then restock
    op("right_to0", M_R, 1'b0);
    op("coin7", M_SW2 | M_SW1, 1'b0);
    op("coin2", M_SW1, 1'b0);
    for (int i = 0; i < 3; i++) op("buy_item0", M_U, 1'b0);
    op("coin3", M_SW1 | M_SW0, 1'b0);
    op("buy_soldout", M_U, 1'b0);
    op("restock", M_L | M_R, 1'b0);
    op("buy_restocked", M_U, 1'b0);

    // Refund with presses during the indication that must be ignored
    op("coin7b", M_SW2 | M_SW1, 1'b0);
    op("refund", M_D, 1'b1);

    // Saturation, then cancel beats buy
    for (int i = 0; i < 26; i++) op("coin_sat", M_SW3, 1'b0);
    op("cancel_over_buy", M_U | M_D, 1'b0);

    // Reset in the middle of a vend aborts it and loses credit
    op("coin10b", M_SW3, 1'b0);
    model_op("buy_then_reset", M_U);
    drive(M_U);
    @(negedge clk);
    e = sb.pop_front();
    check_val({e.tag, "_gn"}, {RD, GN, YL}, e.ind);
    check_val({e.tag, "_led"}, LED, e.led);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_reset_ind", {RD, GN, YL}, IND_NONE);
    check_val("async_reset_led", LED, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    op("coin_after_reset", M_SW0, 1'b0);
    op("buy_after_reset", M_U, 1'b0);

    check_val("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
